// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction-fetch stage
package ifetch_pkg;
    typedef enum logic [1:0] {EMPTY, FULL, FAULT} state_t;
    localparam int INSTR_W = 32;
    localparam int ADDR_W = 32;
    localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;
    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/ifetch_fault_chk.sv
// ifetch_fault_chk: flags misaligned or out-of-range fetch addresses
module ifetch_fault_chk import ifetch_pkg::*; #(
    parameter int IMEM_BYTES = 1024
) (
    input  logic [ADDR_W-1:0] pc,
    output logic              bad
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMEM_BYTES - 4);
    assign bad = (pc[1:0] != 2'b00) || (pc > LAST);
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC, imem address and registered fetch output with valid/ready; fault check under IFETCH_FAULT_CHECK_EN
module instr_fetch import ifetch_pkg::*; #(
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int IMEM_BYTES = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               id_ready,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [ADDR_W-1:0]  id_pc,
    output logic [ADDR_W-1:0]  id_pc_plus4,
    output logic               fault,
    output logic [ADDR_W-1:0]  fault_pc
);
    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic              adv;
    logic              bad;
    assign imem_addr = pc;
    assign adv = (state == EMPTY) || (state == FULL && id_ready);
`ifdef IFETCH_FAULT_CHECK_EN
    ifetch_fault_chk #(.IMEM_BYTES(IMEM_BYTES)) u_fault_chk (.pc(pc), .bad(bad));
`else
    assign bad = 1'b0;
`endif
    // redirect outranks the fault check so a redirect is the only way out of FAULT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EMPTY;
            pc          <= RESET_PC;
            id_valid    <= 1'b0;
            id_instr    <= '0;
            id_pc       <= '0;
            id_pc_plus4 <= '0;
            fault       <= 1'b0;
            fault_pc    <= '0;
        end else if (redirect_valid) begin
            state    <= EMPTY;
            pc       <= redirect_pc;
            id_valid <= 1'b0;
            fault    <= 1'b0;
            fault_pc <= '0;
        end else if (adv && bad) begin
            state    <= FAULT;
            id_valid <= 1'b0;
            fault    <= 1'b1;
            fault_pc <= pc;
        end else if (adv) begin
            state       <= FULL;
            id_valid    <= 1'b1;
            id_instr    <= imem_data;
            id_pc       <= pc;
            id_pc_plus4 <= pc + PC_STEP;
            pc          <= pc + PC_STEP;
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: table-driven scoreboard bench for instr_fetch
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_ready = 1'b0;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        fault;
    logic [31:0] fault_pc;
    int checks = 0;
    int errors = 0;
    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] eaddr;
        logic        ef;
        logic [31:0] efpc;
    } vec_t;
    vec_t vecs[$];
    vec_t sb[$];
    vec_t e;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a == 32'h0 ? 32'h2008_0005 : a == 32'h4 ? 32'h2009_0007 : {~a[15:0], a[15:0]};
    endfunction
    assign imem_data = mem_word(imem_addr);

    instr_fetch dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_ready(id_ready),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4),
        .fault(fault), .fault_pc(fault_pc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rv, input logic [31:0] rpc, input logic rdy, input logic ev,
                       input logic [31:0] epc, input logic [31:0] eaddr, input logic ef, input logic [31:0] efpc);
        vecs.push_back('{rv, rpc, rdy, ev, epc, eaddr, ef, efpc});
    endtask

    initial begin
        add(0, 0, 0, 1, 32'h0, 32'h4, 0, 0);
        add(0, 0, 0, 1, 32'h0, 32'h4, 0, 0);
        add(0, 0, 0, 1, 32'h0, 32'h4, 0, 0);
        add(0, 0, 0, 1, 32'h0, 32'h4, 0, 0);
        add(0, 0, 1, 1, 32'h4, 32'h8, 0, 0);
        add(0, 0, 1, 1, 32'h8, 32'hC, 0, 0);
        add(1, 32'h40, 1, 0, 32'h0, 32'h40, 0, 0);
        add(0, 0, 1, 1, 32'h40, 32'h44, 0, 0);
        add(0, 0, 0, 1, 32'h40, 32'h44, 0, 0);
`ifdef IFETCH_FAULT_CHECK_EN
        add(1, 32'h402, 1, 0, 32'h0, 32'h402, 0, 0);
        add(0, 0, 1, 0, 32'h0, 32'h402, 1, 32'h402);
        add(0, 0, 1, 0, 32'h0, 32'h402, 1, 32'h402);
        add(1, 32'h8, 1, 0, 32'h0, 32'h8, 0, 0);
        add(0, 0, 1, 1, 32'h8, 32'hC, 0, 0);
`else
        add(1, 32'hFFFF_FFFC, 0, 0, 32'h0, 32'hFFFF_FFFC, 0, 0);
        add(0, 0, 1, 1, 32'hFFFF_FFFC, 32'h0, 0, 0);
        add(0, 0, 1, 1, 32'h0, 32'h4, 0, 0);
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("reset id_valid", {31'b0, id_valid}, 32'h0);
        chk("reset imem_addr", imem_addr, 32'h0);
        chk("reset id_instr", id_instr, 32'h0);
        chk("reset id_pc", id_pc, 32'h0);
        chk("reset id_pc_plus4", id_pc_plus4, 32'h0);
        chk("reset fault", {31'b0, fault}, 32'h0);
        chk("reset fault_pc", fault_pc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        foreach (vecs[i]) begin
            redirect_valid = vecs[i].rv;
            redirect_pc = vecs[i].rpc;
            id_ready = vecs[i].rdy;
            sb.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk($sformatf("v%0d id_valid", i), {31'b0, id_valid}, {31'b0, e.ev});
            chk($sformatf("v%0d imem_addr", i), imem_addr, e.eaddr);
            chk($sformatf("v%0d fault", i), {31'b0, fault}, {31'b0, e.ef});
            chk($sformatf("v%0d fault_pc", i), fault_pc, e.efpc);
            if (e.ev) begin
                chk($sformatf("v%0d id_pc", i), id_pc, e.epc);
                chk($sformatf("v%0d id_instr", i), id_instr, mem_word(e.epc));
                chk($sformatf("v%0d id_pc_plus4", i), id_pc_plus4, e.epc + 32'd4);
            end
            @(negedge clk);
        end
        redirect_valid = 1'b0;
        id_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("pre-reset id_valid", {31'b0, id_valid}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset id_valid", {31'b0, id_valid}, 32'h0);
        chk("async reset imem_addr", imem_addr, 32'h0);
        chk("async reset fault", {31'b0, fault}, 32'h0);
        chk("async reset id_pc", id_pc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post-reset id_instr", id_instr, 32'h2008_0005);
        chk("post-reset imem_addr", imem_addr, 32'h4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
